// File: rtl/orao_sram_pkg.sv
// Shared types for the Orao SRAM arbiter: FSM states, port encoding and
// the legal range of the access-length parameter.
package orao_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_e;

  typedef enum logic {
    PORT_CPU   = 1'b0,
    PORT_VIDEO = 1'b1
  } port_e;

  localparam int AC_MIN = 1;
  localparam int AC_MAX = 7;
  localparam int CNT_W  = 3;

endpackage

// File: rtl/orao_sram_arbiter.sv
// Shares one 16-bit async SRAM between the CPU byte port and the video word
// port. Every SRAM pin is a flop output; sram_d is tristated here.
module orao_sram_arbiter
  import orao_sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        video_req,
  input  logic [18:0] video_addr,
  output logic [15:0] video_rdata,
  output logic        video_ack,
  output logic [18:0] sram_a,
  inout  wire  [15:0] sram_d,
  output logic        sram_wel,
  output logic        sram_lbl,
  output logic        sram_ubl
);

  if (ACCESS_CYCLES < AC_MIN || ACCESS_CYCLES > AC_MAX) begin : g_bad_access_cycles
    $error("orao_sram_arbiter: ACCESS_CYCLES must be 1..7");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  port_e              last_q, last_d;
  port_e              port_q, port_d;
  logic               lane_q, lane_d;
  logic               d_oe_q, d_oe_d;
  logic [15:0]        d_out_q, d_out_d;
  logic [18:0]        a_d;
  logic               wel_d, lbl_d, ubl_d;
  logic               cpu_ack_d, video_ack_d;
  logic [7:0]         cpu_rdata_d;
  logic [15:0]        video_rdata_d;
  logic               grant_video;

  assign sram_d = d_oe_q ? d_out_q : 16'hzzzz;

  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    last_d        = last_q;
    port_d        = port_q;
    lane_d        = lane_q;
    d_oe_d        = d_oe_q;
    d_out_d       = d_out_q;
    a_d           = sram_a;
    wel_d         = 1'b1;
    lbl_d         = sram_lbl;
    ubl_d         = sram_ubl;
    cpu_ack_d     = 1'b0;
    video_ack_d   = 1'b0;
    cpu_rdata_d   = cpu_rdata;
    video_rdata_d = video_rdata;
    // Under contention video wins unless it had the previous grant.
    grant_video   = video_req && (!cpu_req || last_q == PORT_CPU);

    unique case (state_q)
      IDLE: begin
        if (grant_video) begin
          state_d = READ;
          port_d  = PORT_VIDEO;
          last_d  = PORT_VIDEO;
          a_d     = video_addr;
          lbl_d   = 1'b0;
          ubl_d   = 1'b0;
        end else if (cpu_req) begin
          port_d = PORT_CPU;
          last_d = PORT_CPU;
          lane_d = cpu_addr[0];
          a_d    = cpu_addr[19:1];
          lbl_d  = cpu_addr[0];
          ubl_d  = !cpu_addr[0];
          if (cpu_we) begin
            state_d = WR_SETUP;
            d_oe_d  = 1'b1;
            d_out_d = {cpu_wdata, cpu_wdata};
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          lbl_d   = 1'b1;
          ubl_d   = 1'b1;
          if (port_q == PORT_VIDEO) begin
            video_ack_d   = 1'b1;
            video_rdata_d = sram_d;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = lane_q ? sram_d[15:8] : sram_d[7:0];
          end
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        wel_d   = 1'b0;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             wel_d   = 1'b0;
      end
      WR_HOLD: begin
        state_d   = IDLE;
        d_oe_d    = 1'b0;
        lbl_d     = 1'b1;
        ubl_d     = 1'b1;
        cpu_ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = CNT_LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= PORT_CPU;
      port_q      <= PORT_CPU;
      lane_q      <= 1'b0;
      d_oe_q      <= 1'b0;
      d_out_q     <= '0;
      sram_a      <= '0;
      sram_wel    <= 1'b1;
      sram_lbl    <= 1'b1;
      sram_ubl    <= 1'b1;
      cpu_ack     <= 1'b0;
      video_ack   <= 1'b0;
      cpu_rdata   <= '0;
      video_rdata <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      port_q      <= port_d;
      lane_q      <= lane_d;
      d_oe_q      <= d_oe_d;
      d_out_q     <= d_out_d;
      sram_a      <= a_d;
      sram_wel    <= wel_d;
      sram_lbl    <= lbl_d;
      sram_ubl    <= ubl_d;
      cpu_ack     <= cpu_ack_d;
      video_ack   <= video_ack_d;
      cpu_rdata   <= cpu_rdata_d;
      video_rdata <= video_rdata_d;
    end
  end

endmodule

// File: tb/tb_orao_sram_arbiter.sv
// Directed bench for orao_sram_arbiter: one ACCESS_CYCLES=2 instance with a
// byte-lane SRAM model, plus ACCESS_CYCLES=1/7 instances for latency sweeps.
module tb_orao_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        video_req;
  logic [18:0] video_addr;
  logic [15:0] video_rdata;
  logic        video_ack;
  logic [18:0] sram_a;
  wire  [15:0] sram_d;
  logic        sram_wel, sram_lbl, sram_ubl;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr;
  logic [15:0] pre_data;

  // SRAM model: drives on reads, latches enabled lanes while wel is low.
  assign sram_d = (sram_wel && !(sram_lbl && sram_ubl) && !(cpu_req && cpu_we))
                  ? mem[sram_a[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!sram_wel) begin
      if (!sram_lbl) mem[sram_a[9:0]][7:0]  <= sram_d[7:0];
      if (!sram_ubl) mem[sram_a[9:0]][15:8] <= sram_d[15:8];
    end
  end

  orao_sram_arbiter #(.ACCESS_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .video_req(video_req), .video_addr(video_addr), .video_rdata(video_rdata),
    .video_ack(video_ack),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wel(sram_wel),
    .sram_lbl(sram_lbl), .sram_ubl(sram_ubl)
  );

  logic [1:0]  sw_creq, sw_we, sw_vreq;
  logic        sw_cack [2];
  logic        sw_vack [2];
  logic [7:0]  sw_crd  [2];
  logic [15:0] sw_vrd  [2];

  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int AC = (g == 0) ? 1 : 7;
    logic [18:0] a;
    wire  [15:0] d;
    logic        wel, lbl, ubl;
    assign d = (wel && !(lbl && ubl) && !sw_we[g]) ? (a[15:0] ^ 16'h1234) : 16'hzzzz;
    orao_sram_arbiter #(.ACCESS_CYCLES(AC)) u_sw (
      .clk(clk), .reset(reset),
      .cpu_req(sw_creq[g]), .cpu_we(sw_we[g]), .cpu_addr(20'h00003), .cpu_wdata(8'hA5),
      .cpu_rdata(sw_crd[g]), .cpu_ack(sw_cack[g]),
      .video_req(sw_vreq[g]), .video_addr(19'h00005), .video_rdata(sw_vrd[g]),
      .video_ack(sw_vack[g]),
      .sram_a(a), .sram_d(d), .sram_wel(wel), .sram_lbl(lbl), .sram_ubl(ubl)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] addr, input logic [15:0] data);
    @(negedge clk);
    pre_addr = addr; pre_data = data; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic cpu_txn(input logic we, input logic [19:0] addr, input logic [7:0] wd,
                         output int lat, output logic [9:0] wtr,
                         output logic [18:0] a1, output logic [1:0] en1);
    @(negedge clk);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; wtr = '1; a1 = '0; en1 = '0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 10) wtr[lat] = sram_wel;
      if (lat == 1) begin a1 = sram_a; en1 = {sram_ubl, sram_lbl}; end
      if (cpu_ack) break;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic vid_txn(input logic [18:0] addr, output int lat, output logic [9:0] wtr,
                         output logic [1:0] en1);
    @(negedge clk);
    video_addr = addr; video_req = 1'b1;
    lat = 0; wtr = '1; en1 = '1;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 10) wtr[lat] = sram_wel;
      if (lat == 1) en1 = {sram_ubl, sram_lbl};
      if (video_ack) break;
    end
    video_req = 1'b0;
  endtask

  task automatic sw_txn(input int i, input logic vid, input logic we, output int lat);
    @(negedge clk);
    if (vid) sw_vreq[i] = 1'b1;
    else begin sw_creq[i] = 1'b1; sw_we[i] = we; end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if ((vid && sw_vack[i]) || (!vid && sw_cack[i])) break;
    end
    sw_vreq[i] = 1'b0; sw_creq[i] = 1'b0; sw_we[i] = 1'b0;
  endtask

  initial begin
    int          lat;
    int          n;
    logic [9:0]  wtr;
    logic [18:0] a1;
    logic [1:0]  en1;
    logic [5:0]  seq;
    logic        both;

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    video_req = 1'b0; video_addr = '0; sw_creq = '0; sw_we = '0; sw_vreq = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_a", sram_a, 19'h0);
    chk("rst_wel_lbl_ubl", {sram_wel, sram_lbl, sram_ubl}, 3'b111);
    chk("rst_acks", {cpu_ack, video_ack}, 2'b00);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("rst_vid_rdata", video_rdata, 16'h0000);

    // video word read
    preload(10'h123, 16'hBEEF);
    vid_txn(19'h00123, lat, wtr, en1);
    chk("vid_lat", lat, 3);
    chk("vid_rdata", video_rdata, 16'hBEEF);
    chk("vid_en", en1, 2'b00);
    chk("vid_wel", wtr, 10'h3FF);

    // CPU upper-byte write
    cpu_txn(1'b1, 20'h00247, 8'h5A, lat, wtr, a1, en1);
    chk("wr_lat", lat, 5);
    chk("wr_addr", a1, 19'h00123);
    chk("wr_en", en1, 2'b01);
    chk("wr_wel", wtr, 10'h3F3);
    chk("wr_mem", mem[10'h123], 16'h5AEF);

    // CPU byte reads of both lanes
    preload(10'h123, 16'h5A11);
    cpu_txn(1'b0, 20'h00246, 8'h00, lat, wtr, a1, en1);
    chk("rd_lo_lat", lat, 3);
    chk("rd_lo_en", en1, 2'b10);
    chk("rd_lo", cpu_rdata, 8'h11);
    cpu_txn(1'b0, 20'h00247, 8'h00, lat, wtr, a1, en1);
    chk("rd_hi", cpu_rdata, 8'h5A);

    // both ports requesting continuously out of reset
    @(negedge clk); reset = 1'b1;
    cpu_addr = 20'h00246; cpu_we = 1'b0; cpu_req = 1'b1;
    video_addr = 19'h00123; video_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seq = '0; n = 0; both = 1'b0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(posedge clk); #1;
      if (video_ack && cpu_ack) both = 1'b1;
      if (video_ack) begin seq = {seq[4:0], 1'b1}; n++; end
      else if (cpu_ack) begin seq = {seq[4:0], 1'b0}; n++; end
    end
    cpu_req = 1'b0; video_req = 1'b0;
    chk("arb_count", n, 6);
    chk("arb_seq", seq, 6'b101010);
    chk("arb_both", both, 1'b0);
    chk("arb_cpu_rd", cpu_rdata, 8'h11);
    chk("arb_vid_rd", video_rdata, 16'h5A11);

    // reset during the write pulse
    preload(10'h124, 16'hCAFE);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 20'h00248; cpu_wdata = 8'h77; cpu_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_in_pulse", sram_wel, 1'b0);
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clk); #1;
    chk("abort_wel_lbl_ubl", {sram_wel, sram_lbl, sram_ubl}, 3'b111);
    chk("abort_ack", cpu_ack, 1'b0);
    chk("abort_a", sram_a, 19'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_mem_hi", mem[10'h124][15:8], 8'hCA);
    chk("abort_mem_nbr", mem[10'h123], 16'h5A11);
    vid_txn(19'h00124, lat, wtr, en1);
    chk("abort_rd_lat", lat, 3);
    chk("abort_rd_hi", video_rdata[15:8], 8'hCA);

    // ACCESS_CYCLES = 1 and 7 latency sweeps
    for (int i = 0; i < 2; i++) begin
      sw_txn(i, 1'b0, 1'b0, lat);
      chk("sw_rd_lat", lat, (i == 0) ? 2 : 8);
      chk("sw_rd_data", sw_crd[i], 8'h12);
      sw_txn(i, 1'b0, 1'b1, lat);
      chk("sw_wr_lat", lat, (i == 0) ? 4 : 10);
      sw_txn(i, 1'b1, 1'b0, lat);
      chk("sw_vid_lat", lat, (i == 0) ? 2 : 8);
      chk("sw_vid_data", sw_vrd[i], 16'h1231);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
